game_world_engine: RTL
======================

Name: game_world_engine

Overview:
- Produces the world-side status inputs consumed by the game control FSM: collided, reached_screen_end, and the sampled jump request.
- Advances one scrolling obstacle, the player's jump trajectory and a distance counter once per frame tick while the game is running.
- Sits between the input debouncer/VGA frame timer and the control FSM; its position outputs also feed the drawing logic.

Parameters:
- SCREEN_W, 160, visible screen width in pixels.
- X_W, 8, width of x coordinates.
- Y_W, 7, width of player height.
- PLAYER_X, 20, fixed left x of player.
- PLAYER_W, 8, player width.
- OBST_W, 6, obstacle width.
- OBST_H, 10, obstacle height; player is clear when player_y >= OBST_H.
- SPEED, 2, obstacle pixels moved per frame tick.
- JUMP_H, 24, jump apex height.
- JUMP_STEP, 2, height change per frame tick.
- TRACK_LEN, 1024, frame ticks required to finish the level.
- D_W, 11, distance counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  high while the control FSM is in its playing state
- restart  in  1  single-cycle pulse; returns the world to its reset values
- frame_tick  in  1  single-cycle pulse, once per video frame
- jump_req  in  1  user input; any-length high pulse
- collided  out  1  sticky; set on overlap, cleared by reset or restart
- reached_screen_end  out  1  sticky; set when distance == TRACK_LEN
- player_y  out  Y_W  player height above ground
- obst_x  out  X_W  obstacle left x
- obst_visible  out  1  obst_x < SCREEN_W
- distance  out  D_W  frame ticks advanced

Behaviour:
- Reset and restart:
  - Reset is asynchronous and active-low. Restart is synchronous with identical effect.
  - Values on either: collided=0, reached_screen_end=0, player_y=0, obst_x=SCREEN_W-1, distance=0, jump FSM=GROUND, jump_pending=0, LFSR=8'hA5.
  - Restart has priority over every other event in the same cycle.
- Active tick: frame_tick && run && !collided && !reached_screen_end. With no active tick, all state holds. jump_pending is the one exception and still latches.
- jump_pending:
  - Set on any cycle where jump_req=1.
  - Cleared on every active tick, whether consumed or ignored because the player is airborne.
- Jump FSM (GROUND, RISE, FALL), updated on active ticks only:
  - GROUND with jump_pending: go to RISE. player_y stays 0 this tick.
  - RISE: player_y += JUMP_STEP. When the new value is >= JUMP_H, clamp to JUMP_H and go to FALL.
  - FALL: player_y -= JUMP_STEP. When the new value is <= 0, clamp to 0 and go to GROUND.
  - Jump requests during RISE or FALL are dropped.
- Obstacle, on each active tick:
  - If obst_x < SPEED: obst_x = SCREEN_W-1 + lfsr[5:0] (max 222, fits X_W).
  - Otherwise: obst_x -= SPEED.
  - LFSR (x^8+x^6+x^5+x^4+1, Fibonacci) advances once per active tick. The wrap uses the pre-advance value.
- distance: increments per active tick and saturates at TRACK_LEN.
- Collision check:
  - Evaluated every cycle on registered values, using X_W+1-bit arithmetic.
  - Overlap = obst_x < PLAYER_X+PLAYER_W && obst_x+OBST_W > PLAYER_X && player_y < OBST_H.
  - If overlap && run: collided=1 on the next edge. Latency is 1 cycle after the tick that created the overlap.
- End check: reached_screen_end is set on the edge after distance reaches TRACK_LEN, but only if collided is not set in that same edge. Collision has priority.
- Freeze: once either flag is set, the world freezes until restart.
- run=0: world pauses, no collision is registered, flags hold.

Decomposition:
- Package game_pkg:
  - jump state encoding: GROUND=2'd0, RISE=2'd1, FALL=2'd2.
  - screen constants SCREEN_W, PLAYER_X, PLAYER_W.
  - LFSR seed 8'hA5 and tap mask.
  - The control FSM imports the same package.
- Sub-module lfsr8 (clock, reset, restart, advance, q[7:0]), reused later for obstacle height variation.

Test Plan:
- Reset low mid-run, then high → obst_x=159, player_y=0, distance=0, both flags 0, obst_visible=1.
- run=1, 3-cycle jump_req pulse between ticks → RISE on next tick; player_y=24 after tick 13; player_y=0 and GROUND after tick 25; second jump_req during FALL ignored.
- run=1, no jumps → obst_x=27 after tick 66; collided=1 one cycle later; further ticks leave obst_x=27 and distance=66.
- TRACK_LEN=16, run=1 → distance=16, obst_x=127, reached_screen_end=1 one cycle after tick 16, collided=0.
- Force overlap and distance==TRACK_LEN on the same tick → only collided=1. Then restart pulse → all values back to reset, LFSR=8'hA5.
- Let the obstacle wrap with jumps timed to clear it → on the tick where obst_x<2, obst_x = 159 + lfsr[5:0] of the pre-advance LFSR value; run=0 for 10 ticks → no state change.

Source files
------------

// File: rtl/game_pkg.sv
// Constants shared by the world engine and the game control FSM.
// Covers screen geometry, jump tuning, jump state codes and the obstacle LFSR.
package game_pkg;

  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int SCREEN_W  = 160;
  localparam int PLAYER_X  = 20;
  localparam int PLAYER_W  = 8;
  localparam int OBST_W    = 6;
  localparam int OBST_H    = 10;
  localparam int SPEED     = 2;
  localparam int JUMP_H    = 24;
  localparam int JUMP_STEP = 2;

  localparam logic [1:0] GROUND = 2'd0;
  localparam logic [1:0] RISE   = 2'd1;
  localparam logic [1:0] FALL   = 2'd2;

  // x^8+x^6+x^5+x^4+1 in Fibonacci form, shifting toward the MSB.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit pseudo-random source for obstacle placement.
// The generator steps only when advance_i is high; restart reseeds it.
module lfsr8
  import game_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       restart_i,
  input  logic       advance_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  assign q_d = advance_i ? lfsr_next(q_q) : q_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      q_q <= LFSR_SEED;
    end else if (restart_i) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/game_world_engine.sv
// World state for the runner game: obstacle scroll, jump arc, distance and status flags.
// State | meaning: GROUND = on the floor, waiting for a jump; RISE = climbing to apex; FALL = descending.
module game_world_engine
  import game_pkg::*;
#(
  parameter int unsigned TRACK_LEN = 1024,
  parameter int unsigned D_W       = 11
) (
  input  logic           clock_i,
  input  logic           reset_ni,
  input  logic           run_i,
  input  logic           restart_i,
  input  logic           frame_tick_i,
  input  logic           jump_req_i,
  output logic           collided_o,
  output logic           reached_screen_end_o,
  output logic [Y_W-1:0] player_y_o,
  output logic [X_W-1:0] obst_x_o,
  output logic           obst_visible_o,
  output logic [D_W-1:0] distance_o
);

  localparam logic [X_W:0]   PL_L_EXT    = (X_W+1)'(PLAYER_X);
  localparam logic [X_W:0]   PL_R_EXT    = (X_W+1)'(PLAYER_X + PLAYER_W);
  localparam logic [X_W:0]   OBST_W_EXT  = (X_W+1)'(OBST_W);
  localparam logic [X_W-1:0] OBST_START  = X_W'(SCREEN_W - 1);
  localparam logic [X_W-1:0] SCREEN_X    = X_W'(SCREEN_W);
  localparam logic [X_W-1:0] SPEED_X     = X_W'(SPEED);
  localparam logic [Y_W-1:0] OBST_H_Y    = Y_W'(OBST_H);
  localparam logic [Y_W-1:0] JUMP_H_Y    = Y_W'(JUMP_H);
  localparam logic [Y_W-1:0] JUMP_STEP_Y = Y_W'(JUMP_STEP);
  localparam logic [D_W-1:0] TRACK_D     = D_W'(TRACK_LEN);

  logic           collided_q, collided_d;
  logic           reached_q, reached_d;
  logic           jump_pend_q, jump_pend_d;
  logic [1:0]     jump_st_q, jump_st_d;
  logic [Y_W-1:0] player_y_q, player_y_d;
  logic [Y_W-1:0] y_up;
  logic [X_W-1:0] obst_x_q, obst_x_d;
  logic [D_W-1:0] distance_q, distance_d;
  logic [X_W:0]   ox_ext;
  logic [7:0]     lfsr_q;
  logic           active;
  logic           overlap;
  logic           coll_set;
  logic           reach_set;
  logic           unused_lfsr_hi;

  assign active = frame_tick_i & run_i & ~collided_q & ~reached_q;

  lfsr8 u_lfsr (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .restart_i (restart_i),
    .advance_i (active),
    .q_o       (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[7:6];

  // Overlap is judged on registered positions, one bit wider so x+width never wraps.
  assign ox_ext  = {1'b0, obst_x_q};
  assign overlap = (ox_ext < PL_R_EXT) &&
                   ((ox_ext + OBST_W_EXT) > PL_L_EXT) &&
                   (player_y_q < OBST_H_Y);

  assign coll_set    = overlap & run_i & ~reached_q;
  assign reach_set   = (distance_q == TRACK_D) & ~collided_q & ~coll_set;
  assign collided_d  = collided_q | coll_set;
  assign reached_d   = reached_q | reach_set;
  assign jump_pend_d = active ? 1'b0 : (jump_pend_q | jump_req_i);

  always_comb begin
    jump_st_d  = jump_st_q;
    player_y_d = player_y_q;
    y_up       = player_y_q + JUMP_STEP_Y;
    if (active) begin
      case (jump_st_q)
        GROUND: begin
          if (jump_pend_q) jump_st_d = RISE;
        end
        RISE: begin
          if (y_up >= JUMP_H_Y) begin
            player_y_d = JUMP_H_Y;
            jump_st_d  = FALL;
          end else begin
            player_y_d = y_up;
          end
        end
        FALL: begin
          if (player_y_q <= JUMP_STEP_Y) begin
            player_y_d = '0;
            jump_st_d  = GROUND;
          end else begin
            player_y_d = player_y_q - JUMP_STEP_Y;
          end
        end
        default: begin
          player_y_d = '0;
          jump_st_d  = GROUND;
        end
      endcase
    end
  end

  // The wrap position uses the LFSR value from before this tick's advance.
  always_comb begin
    obst_x_d   = obst_x_q;
    distance_d = distance_q;
    if (active) begin
      if (obst_x_q < SPEED_X) begin
        obst_x_d = OBST_START + X_W'(lfsr_q[5:0]);
      end else begin
        obst_x_d = obst_x_q - SPEED_X;
      end
      if (distance_q < TRACK_D) distance_d = distance_q + D_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      collided_q  <= 1'b0;
      reached_q   <= 1'b0;
      jump_pend_q <= 1'b0;
      jump_st_q   <= GROUND;
      player_y_q  <= '0;
      obst_x_q    <= OBST_START;
      distance_q  <= '0;
    end else if (restart_i) begin
      collided_q  <= 1'b0;
      reached_q   <= 1'b0;
      jump_pend_q <= 1'b0;
      jump_st_q   <= GROUND;
      player_y_q  <= '0;
      obst_x_q    <= OBST_START;
      distance_q  <= '0;
    end else begin
      collided_q  <= collided_d;
      reached_q   <= reached_d;
      jump_pend_q <= jump_pend_d;
      jump_st_q   <= jump_st_d;
      player_y_q  <= player_y_d;
      obst_x_q    <= obst_x_d;
      distance_q  <= distance_d;
    end
  end

  assign collided_o           = collided_q;
  assign reached_screen_end_o = reached_q;
  assign player_y_o           = player_y_q;
  assign obst_x_o             = obst_x_q;
  assign obst_visible_o       = obst_x_q < SCREEN_X;
  assign distance_o           = distance_q;

endmodule
